// File: rtl/iec_sd_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// iec_sd_arbiter_pkg
// Shared definitions for the SD host arbiter:
//   arb_state_t  - arbiter FSM state encoding (IDLE / REQ / XFER)
//   MAX_DRIVES   - largest supported number of drive request ports
//   ndr_clamp()  - clamps the DRIVES parameter into 1..MAX_DRIVES
// -----------------------------------------------------------------------------
package iec_sd_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } arb_state_t;

    localparam int MAX_DRIVES = 4;

    function automatic int ndr_clamp(input int drives);
        if (drives < 1) begin
            return 1;
        end
        if (drives > MAX_DRIVES) begin
            return MAX_DRIVES;
        end
        return drives;
    endfunction

endpackage

// File: rtl/iec_sd_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// iec_rr_pick
// Combinational round-robin selector. Picks the requesting port closest after
// the last granted port, wrapping modulo NDR.
// Ports:
//   req   [NDR-1:0] in   request vector, one bit per drive
//   last  [1:0]     in   index of the previously granted drive
//   idx   [1:0]     out  index of the next drive to grant
//   valid           out  at least one request is pending
// -----------------------------------------------------------------------------
module iec_rr_pick #(
    parameter int NDR = 2
) (
    input  logic [NDR-1:0] req,
    input  logic [1:0]     last,
    output logic [1:0]     idx,
    output logic           valid
);

    logic [2:0] best;

    // Distance of a port from the search start (last+1); 0 is searched first.
    // The 8 offset keeps the dividend positive for every legal 'last'.
    function automatic logic [2:0] rr_dist(input int pos, input logic [1:0] from);
        int d;
        d = (pos + 8 - int'(from) - 1) % NDR;
        return d[2:0];
    endfunction

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        best  = 3'd7;
        for (int i = 0; i < NDR; i++) begin
            if (req[i] && (rr_dist(i, last) < best)) begin
                best  = rr_dist(i, last);
                idx   = 2'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iec_sd_arbiter.sv
// -----------------------------------------------------------------------------
// iec_sd_arbiter
// Arbitrates up to four drive request ports onto a single SD host interface.
// A drive is granted round-robin, its address/count/direction are latched and
// the host request is held until the host acknowledges or the request times
// out.
// Parameters:
//   DRIVES  number of drive ports (clamped to 1..4 -> NDR)
//   TMO_W   width of the request-timeout counter
// Ports:
//   clk_sys               in   clock, rising edge
//   reset                 in   synchronous active-high reset
//   drv_lba[NDR]     [31:0] in  per-drive block address
//   drv_blk_cnt[NDR] [5:0]  in  per-drive block count minus one
//   drv_rd, drv_wr   [NDR]  in  per-drive request levels
//   drv_buff_din[NDR][7:0]  in  per-drive write data
//   drv_ack          [NDR]  out per-drive acknowledge (combinational)
//   sd_lba           [31:0] out latched block address
//   sd_blk_cnt       [5:0]  out latched block count
//   sd_rd, sd_wr            out host request levels
//   sd_ack                  in  host acknowledge
//   sd_buff_din      [7:0]  out write data from the granted drive
//   grant            [1:0]  out current / last granted drive
//   busy                    out FSM not in IDLE
//   tmo                     out one-cycle timeout pulse
// -----------------------------------------------------------------------------
module iec_sd_arbiter
    import iec_sd_arbiter_pkg::*;
#(
    parameter int  DRIVES = 2,
    parameter int  TMO_W  = 24,
    localparam int NDR    = ndr_clamp(DRIVES)
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [31:0]       drv_lba      [NDR],
    input  logic [5:0]        drv_blk_cnt  [NDR],
    input  logic [NDR-1:0]    drv_rd,
    input  logic [NDR-1:0]    drv_wr,
    input  logic [7:0]        drv_buff_din [NDR],
    output logic [NDR-1:0]    drv_ack,
    output logic [31:0]       sd_lba,
    output logic [5:0]        sd_blk_cnt,
    output logic              sd_rd,
    output logic              sd_wr,
    input  logic              sd_ack,
    output logic [7:0]        sd_buff_din,
    output logic [1:0]        grant,
    output logic              busy,
    output logic              tmo
);

    // The timeout fires on the edge where the counter steps onto all-ones,
    // so the request stays up for 2**TMO_W - 1 REQ cycles.
    localparam logic [TMO_W-1:0] TMO_LAST = {TMO_W{1'b1}} - TMO_W'(1);

    arb_state_t        state;
    logic [1:0]        sel;
    logic [TMO_W-1:0]  tmo_cnt;

    logic [1:0]        pick_idx;
    logic              pick_vld;
    logic [31:0]       pick_lba;
    logic [5:0]        pick_cnt;
    logic              pick_rd;

    iec_rr_pick #(
        .NDR   (NDR)
    ) u_pick (
        .req   (drv_rd | drv_wr),
        .last  (grant),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    // Port muxes: candidate fields for the next grant, and the live data /
    // acknowledge path of the currently selected drive.
    always_comb begin
        pick_lba    = '0;
        pick_cnt    = '0;
        pick_rd     = 1'b0;
        sd_buff_din = '0;
        drv_ack     = '0;
        for (int i = 0; i < NDR; i++) begin
            if (pick_idx == 2'(i)) begin
                pick_lba = drv_lba[i];
                pick_cnt = drv_blk_cnt[i];
                pick_rd  = drv_rd[i];
            end
            if (sel == 2'(i)) begin
                sd_buff_din = drv_buff_din[i];
                drv_ack[i]  = sd_ack & (state != IDLE);
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            sel        <= '0;
            grant      <= 2'(NDR - 1);
            sd_lba     <= '0;
            sd_blk_cnt <= '0;
            tmo        <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            tmo <= 1'b0;
            unique case (state)
                IDLE: begin
                    // A still-high sd_ack belongs to a transfer abandoned by
                    // reset; wait for the host to release it.
                    if (!sd_ack && pick_vld) begin
                        sel        <= pick_idx;
                        grant      <= pick_idx;
                        sd_lba     <= pick_lba;
                        sd_blk_cnt <= pick_cnt;
                        sd_rd      <= pick_rd;
                        sd_wr      <= ~pick_rd;
                        tmo_cnt    <= '0;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (sd_ack) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        state <= XFER;
                    end else if (tmo_cnt == TMO_LAST) begin
                        sd_rd <= 1'b0;
                        sd_wr <= 1'b0;
                        tmo   <= 1'b1;
                        state <= IDLE;
                    end
                end
                XFER: begin
                    if (!sd_ack) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iec_sd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_iec_sd_arbiter
// Self-checking bench for iec_sd_arbiter (4 drives, 4-bit timeout). The bench
// plays the SD host and checks every transaction against a round-robin
// reference that tracks only the last granted drive.
// -----------------------------------------------------------------------------
module tb_iec_sd_arbiter;

    localparam int NDR     = 4;
    localparam int TMO_W   = 4;
    localparam int TMO_CYC = (1 << TMO_W) - 1;

    logic           clk_sys = 1'b0;
    logic           reset;
    logic [31:0]    drv_lba      [NDR];
    logic [5:0]     drv_blk_cnt  [NDR];
    logic [NDR-1:0] drv_rd;
    logic [NDR-1:0] drv_wr;
    logic [7:0]     drv_buff_din [NDR];
    logic [NDR-1:0] drv_ack;
    logic [31:0]    sd_lba;
    logic [5:0]     sd_blk_cnt;
    logic           sd_rd;
    logic           sd_wr;
    logic           sd_ack;
    logic [7:0]     sd_buff_din;
    logic [1:0]     grant;
    logic           busy;
    logic           tmo;

    int total = 0;
    int bad   = 0;
    int last_grant;

    iec_sd_arbiter #(
        .DRIVES       (NDR),
        .TMO_W        (TMO_W)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .drv_lba      (drv_lba),
        .drv_blk_cnt  (drv_blk_cnt),
        .drv_rd       (drv_rd),
        .drv_wr       (drv_wr),
        .drv_buff_din (drv_buff_din),
        .drv_ack      (drv_ack),
        .sd_lba       (sd_lba),
        .sd_blk_cnt   (sd_blk_cnt),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_din  (sd_buff_din),
        .grant        (grant),
        .busy         (busy),
        .tmo          (tmo)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Reference arbitration: first requester found walking forward from the
    // drive after the last one granted.
    function automatic int model_pick();
        for (int k = 1; k <= NDR; k++) begin
            int c;
            c = (last_grant + k) % NDR;
            if (drv_rd[c] || drv_wr[c]) begin
                return c;
            end
        end
        return -1;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        check("rst.busy",  busy,       0);
        check("rst.sd_rd", sd_rd,      0);
        check("rst.sd_wr", sd_wr,      0);
        check("rst.tmo",   tmo,        0);
        check("rst.lba",   sd_lba,     0);
        check("rst.cnt",   sd_blk_cnt, 0);
        check("rst.grant", grant,      NDR - 1);
        check("rst.ack",   drv_ack,    0);
        reset = 1'b0;
        last_grant = NDR - 1;
    endtask

    // One complete host transaction. Called in an IDLE cycle with requests
    // already applied; returns the drive the DUT granted.
    task automatic serve(input string tag, input int ack_dly, input int hold,
                         input bit drop, output int got);
        int             exp;
        int             waited;
        logic           exp_rd;
        logic [31:0]    exp_lba;
        logic [5:0]     exp_cnt;
        logic [NDR-1:0] oh;
        exp     = model_pick();
        exp_rd  = drv_rd[exp];
        exp_lba = drv_lba[exp];
        exp_cnt = drv_blk_cnt[exp];
        oh      = '0;
        oh[exp] = 1'b1;
        waited  = 0;
        while (!(sd_rd || sd_wr) && waited < 20) begin
            tick();
            waited++;
        end
        check($sformatf("%s.latency", tag), waited, 1);
        got = int'(grant);
        check($sformatf("%s.grant", tag), grant, exp);
        check($sformatf("%s.lba", tag), sd_lba, exp_lba);
        check($sformatf("%s.cnt", tag), sd_blk_cnt, exp_cnt);
        check($sformatf("%s.rd", tag), sd_rd, exp_rd);
        check($sformatf("%s.wr", tag), sd_wr, !exp_rd);
        check($sformatf("%s.busy", tag), busy, 1);
        #1;
        check($sformatf("%s.din", tag), sd_buff_din, drv_buff_din[exp]);
        check($sformatf("%s.ack0", tag), drv_ack, 0);
        if (drop) begin
            drv_rd[exp] = 1'b0;
            drv_wr[exp] = 1'b0;
        end
        for (int j = 0; j < ack_dly; j++) begin
            tick();
            check($sformatf("%s.hold_rd", tag), sd_rd, exp_rd);
            check($sformatf("%s.hold_wr", tag), sd_wr, !exp_rd);
            check($sformatf("%s.pre_ack", tag), drv_ack, 0);
        end
        sd_ack = 1'b1;
        #1;
        check($sformatf("%s.drv_ack", tag), drv_ack, oh);
        tick();
        check($sformatf("%s.rd_clr", tag), sd_rd, 0);
        check($sformatf("%s.wr_clr", tag), sd_wr, 0);
        check($sformatf("%s.xfer_busy", tag), busy, 1);
        check($sformatf("%s.xfer_ack", tag), drv_ack, oh);
        for (int j = 0; j < hold; j++) begin
            for (int i = 0; i < NDR; i++) begin
                drv_lba[i]     = $urandom;
                drv_blk_cnt[i] = 6'($urandom);
            end
            tick();
            check($sformatf("%s.keep_lba", tag), sd_lba, exp_lba);
            check($sformatf("%s.keep_cnt", tag), sd_blk_cnt, exp_cnt);
            check($sformatf("%s.keep_ack", tag), drv_ack, oh);
        end
        sd_ack = 1'b0;
        #1;
        check($sformatf("%s.ack_drop", tag), drv_ack, 0);
        tick();
        check($sformatf("%s.gap_busy", tag), busy, 0);
        check($sformatf("%s.gap_rd", tag), sd_rd | sd_wr, 0);
        last_grant = exp;
    endtask

    initial begin
        int got;
        int hi;
        int pulses;

        reset  = 1'b1;
        sd_ack = 1'b0;
        drv_rd = '0;
        drv_wr = '0;
        for (int i = 0; i < NDR; i++) begin
            drv_lba[i]      = 32'h1000 + 32'(i);
            drv_blk_cnt[i]  = 6'(i);
            drv_buff_din[i] = 8'(i);
        end
        do_reset();

        // Single read from drive 0.
        drv_lba[0]     = 32'h168;
        drv_blk_cnt[0] = 6'd7;
        drv_rd         = 4'b0001;
        serve("rd1", 3, 512, 1'b0, got);
        check("rd1.drive", got, 0);
        drv_rd = '0;

        // Simultaneous requests after reset: drive 0 then drive 1.
        do_reset();
        drv_rd = 4'b0011;
        serve("sim_a", 2, 3, 1'b0, got);
        check("sim_a.drive", got, 0);
        serve("sim_b", 1, 2, 1'b0, got);
        check("sim_b.drive", got, 1);
        drv_rd = '0;

        // Fairness with every drive requesting.
        do_reset();
        drv_rd = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            serve("fair", 1, 1, 1'b0, got);
            check("fair.order", got, k % NDR);
        end
        drv_rd = '0;

        // Write from drive 1, then rd+wr on drive 2 resolves to a read.
        drv_wr          = 4'b0010;
        drv_buff_din[1] = 8'hA5;
        serve("wr1", 2, 2, 1'b0, got);
        check("wr1.drive", got, 1);
        drv_wr = 4'b0100;
        drv_rd = 4'b0100;
        serve("rdwr", 1, 1, 1'b0, got);
        check("rdwr.drive", got, 2);
        drv_rd = '0;
        drv_wr = '0;

        // Timeout: drive 3 requests, the host never answers.
        drv_rd = 4'b1000;
        tick();
        check("tmo.grant", grant, 3);
        hi     = 0;
        pulses = 0;
        while (sd_rd && hi < 40) begin
            hi++;
            pulses += int'(tmo);
            tick();
        end
        check("tmo.len",   hi,     TMO_CYC);
        check("tmo.early", pulses, 0);
        check("tmo.pulse", tmo,    1);
        check("tmo.busy",  busy,   0);
        drv_rd = '0;
        tick();
        check("tmo.once",  tmo,    0);
        last_grant = 3;

        // Reset in XFER with the host still acknowledging.
        drv_rd = 4'b1001;
        tick();
        check("rx.grant", grant, 0);
        check("rx.rd",    sd_rd, 1);
        sd_ack = 1'b1;
        tick();
        check("rx.xfer",  busy,  1);
        do_reset();
        for (int j = 0; j < 10; j++) begin
            tick();
            check("rx.blocked", busy,  0);
            check("rx.no_rd",   sd_rd, 0);
            check("rx.no_ack",  drv_ack, 0);
        end
        sd_ack = 1'b0;
        drv_rd = 4'b0001;
        serve("rx_after", 2, 2, 1'b0, got);
        check("rx_after.drive", got, 0);
        drv_rd = '0;

        // Randomized traffic, including drives that drop their request early.
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < NDR; i++) begin
                drv_lba[i]      = $urandom;
                drv_blk_cnt[i]  = 6'($urandom);
                drv_buff_din[i] = 8'($urandom);
            end
            do begin
                drv_rd = 4'($urandom);
                drv_wr = 4'($urandom);
            end while ((drv_rd | drv_wr) == '0);
            serve("rnd", int'($urandom_range(0, 10)), int'($urandom_range(0, 6)),
                  1'($urandom_range(0, 1)), got);
        end
        drv_rd = '0;
        drv_wr = '0;
        tick();
        check("end.idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iec_sd_arbiter.md
IEC_SD_ARBITER -- requirements
Module: iec_sd_arbiter

Interface
REQ-001 Parameter DRIVES, default 2, number of drive request ports; clamped to NDR = 1..4, N = NDR-1.
REQ-002 Parameter TMO_W, default 24, width of the request-timeout counter.
REQ-003 clk_sys  in  1  single clock; all logic on its rising edge.
REQ-004 reset  in  1  reset is synchronous and active-high.
REQ-005 drv_lba[NDR]  in  32  per-drive block address.
REQ-006 drv_blk_cnt[NDR]  in  6  per-drive block count minus one.
REQ-007 drv_rd, drv_wr  in  N+1 each  per-drive read/write request levels.
REQ-008 drv_buff_din[NDR]  in  8  per-drive write data.
REQ-009 drv_ack  out  N+1  per-drive acknowledge.
REQ-010 sd_lba  out  32  latched block address to the host.
REQ-011 sd_blk_cnt  out  6  latched block count to the host.
REQ-012 sd_rd, sd_wr  out  1 each  host request levels.
REQ-013 sd_ack  in  1  host acknowledge.
REQ-014 sd_buff_din  out  8  write data to the host from the granted drive.
REQ-015 grant  out  2  index of the current or last granted drive.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 tmo  out  1  one-cycle pulse when a request times out.

Function
REQ-018 The FSM SHALL have three states: IDLE, REQ and XFER.
REQ-019 IDLE: when sd_ack=0 and any drv_rd|drv_wr bit is set, the block SHALL grant one drive round-robin, searching from grant+1 modulo NDR.
REQ-020 IDLE grant: the block SHALL latch sel, sd_lba, sd_blk_cnt and the direction, with rd winning over wr when both are set on one drive, then move to REQ.
REQ-021 IDLE with sd_ack=1 (stale from before reset): the block SHALL stay in IDLE and make no grant.
REQ-022 REQ: registered sd_rd or sd_wr SHALL be 1 per the latched direction, going high the cycle after the grant.
REQ-023 REQ: when sd_ack=1 the block SHALL clear sd_rd/sd_wr on the next edge and move to XFER.
REQ-024 REQ: if the granted drive drops its request before the ack, the request SHALL stay asserted until ack; the transfer completes normally.
REQ-025 XFER: on sd_ack=0 the block SHALL return to IDLE, giving at least one idle cycle between grants.
REQ-026 drv_ack[i] SHALL equal sd_ack AND sel==i AND state is REQ or XFER; combinational, zero latency; all other bits 0.
REQ-027 sd_buff_din SHALL equal drv_buff_din[sel] combinationally in every state.
REQ-028 Timeout: the counter SHALL clear on entry to REQ and increment each REQ cycle.
REQ-029 When the counter reaches all-ones, the block SHALL deassert sd_rd/sd_wr, pulse tmo for one cycle and go to IDLE; grant advances normally afterwards.
REQ-030 sd_lba and sd_blk_cnt SHALL hold their values from grant until the next grant.

Reset
REQ-031 On reset the block SHALL force state=IDLE, sd_rd=0, sd_wr=0, sel=0, grant=N (so drive 0 is searched first), sd_lba=0, sd_blk_cnt=0, tmo=0, busy=0 and timeout counter=0.
REQ-032 drv_ack SHALL be all 0 during and after reset until the next grant.
REQ-033 Reset during XFER: the block SHALL abandon the transfer; REQ-021 blocks new grants until the host drops sd_ack.

Structure
REQ-034 A shared package SHALL hold the state enum (IDLE/REQ/XFER) and the NDR clamp function.
REQ-035 One sub-module, iec_rr_pick, SHALL be used: a combinational round-robin selector (request vector, last grant -> next index, valid).
REQ-036 The FSM, latches and timeout counter SHALL live in iec_sd_arbiter.

Verification
REQ-037 Single read: drive 0 drv_rd=1 with lba=0x168, host acks 3 cycles later and holds for 512 cycles -> sd_lba=0x168, sd_rd high until ack, drv_ack[0] mirrors sd_ack, drv_ack[1]=0.
REQ-038 Simultaneous requests: DRIVES=2, rd on drives 0 and 1 in the same cycle after reset -> drive 0 is served first, drive 1 second, with an idle gap of at least one cycle between them.
REQ-039 Fairness: DRIVES=4, all drives request continuously -> grant order is 0,1,2,3,0.
REQ-040 Write data: drive 1 drv_wr=1 with drv_buff_din=0xA5 -> sd_wr=1, sd_buff_din=0xA5 and rd-only logic idle; with rd and wr both set, sd_rd is chosen.
REQ-041 Timeout: TMO_W=4, request with no ack -> after 15 REQ cycles sd_rd=0, tmo pulses once, state=IDLE.
REQ-042 Reset mid-XFER with sd_ack held high for 10 cycles and drive 0 still requesting -> no grant until sd_ack=0, then drive 0 is granted.
